// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : axi_mem_responder
// Brief   : AXI4 subordinate memory model with FIXED/INCR/WRAP bursts, byte
//           strobes and programmable first-beat read latency. Optional
//           DECERR on out-of-range addresses via AXI_MEM_ERR_RESP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module axi_mem_responder #(
  parameter int ID_WIDTH     = 13,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready
);

  localparam int c_IDX_W = $clog2(MEM_WORDS);
  localparam int c_LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [1:0] c_BURST_FIXED = 2'b00;
  localparam logic [1:0] c_BURST_WRAP  = 2'b10;
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  localparam logic [1:0] c_R_IDLE  = 2'd0;
  localparam logic [1:0] c_R_WAIT  = 2'd1;
  localparam logic [1:0] c_R_BURST = 2'd2;
  localparam logic [1:0] c_W_IDLE  = 2'd0;
  localparam logic [1:0] c_W_DATA  = 2'd1;
  localparam logic [1:0] c_W_RESP  = 2'd2;

  // Byte address of a beat; unsupported WRAP lengths fall back to INCR.
  function automatic logic [ADDR_WIDTH-1:0] f_beat_addr(
    input logic [ADDR_WIDTH-1:0] start,
    input logic [7:0]            len,
    input logic [1:0]            burst,
    input logic [7:0]            beat
  );
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;
    incr = start + {{(ADDR_WIDTH-11){1'b0}}, beat, 3'b000};
    mask = {{(ADDR_WIDTH-11){1'b0}}, len, 3'b111};
    if (burst == c_BURST_FIXED)
      return start;
    else if (burst == c_BURST_WRAP &&
             (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return (start & ~mask) | (incr & mask);
    else
      return incr;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // ---------------------------------------------------------------- read side
  logic [1:0]            r_rstate;
  logic [1:0]            w_rstate_nxt;
  logic [ID_WIDTH-1:0]   r_arid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [1:0]            r_arburst;
  logic [7:0]            r_rbeat;
  logic [c_LAT_W-1:0]    r_lat_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_r_last;
  logic                  w_rd_present;
  logic [7:0]            w_rd_load_beat;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [c_IDX_W-1:0]    w_rd_idx;
  logic                  w_rd_err;

  assign w_ar_hs        = (r_rstate == c_R_IDLE) && s_axi_arvalid;
  assign w_r_hs         = (r_rstate == c_R_BURST) && s_axi_rready;
  assign w_r_last       = (r_rbeat == r_arlen);
  assign w_rd_present   = ((r_rstate == c_R_WAIT) && (r_lat_cnt == '0)) ||
                          (w_r_hs && !w_r_last);
  assign w_rd_load_beat = (r_rstate == c_R_WAIT) ? 8'd0 : r_rbeat + 8'd1;
  assign w_rd_addr      = f_beat_addr(r_araddr, r_arlen, r_arburst, w_rd_load_beat);
  assign w_rd_idx       = w_rd_addr[c_IDX_W+2:3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rstate <= c_R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      c_R_IDLE:  if (s_axi_arvalid)       w_rstate_nxt = c_R_WAIT;
      c_R_WAIT:  if (r_lat_cnt == '0)     w_rstate_nxt = c_R_BURST;
      c_R_BURST: if (w_r_hs && w_r_last)  w_rstate_nxt = c_R_IDLE;
      default:                            w_rstate_nxt = c_R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = (r_rstate == c_R_IDLE);
    s_axi_rvalid  = (r_rstate == c_R_BURST);
    s_axi_rlast   = (r_rstate == c_R_BURST) && w_r_last;
    s_axi_rid     = r_arid;
    s_axi_rdata   = r_rdata;
    s_axi_rresp   = r_rresp;
  end

  // Beat data is captured when presented, so a same-cycle write is not seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arburst <= '0;
      r_rbeat   <= '0;
      r_lat_cnt <= '0;
      r_rdata   <= '0;
      r_rresp   <= c_RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_arid    <= s_axi_arid;
        r_araddr  <= s_axi_araddr;
        r_arlen   <= s_axi_arlen;
        r_arburst <= s_axi_arburst;
        r_rbeat   <= '0;
        r_lat_cnt <= c_LAT_W'(READ_LATENCY - 1);
      end
      if ((r_rstate == c_R_WAIT) && (r_lat_cnt != '0))
        r_lat_cnt <= r_lat_cnt - 1'b1;
      if (w_rd_present) begin
        r_rdata <= w_rd_err ? '0 : r_mem[w_rd_idx];
        r_rresp <= w_rd_err ? c_RESP_DECERR : c_RESP_OKAY;
      end
      if (w_r_hs && !w_r_last)
        r_rbeat <= r_rbeat + 8'd1;
    end
  end

  // --------------------------------------------------------------- write side
  logic [1:0]            r_wstate;
  logic [1:0]            w_wstate_nxt;
  logic [ID_WIDTH-1:0]   r_awid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic [1:0]            r_awburst;
  logic [7:0]            r_wbeat;
  logic                  r_wlast_bad;
  logic                  r_dec_err;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_w_last;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [c_IDX_W-1:0]    w_wr_idx;
  logic                  w_wr_err;

  assign w_aw_hs   = (r_wstate == c_W_IDLE) && s_axi_awvalid;
  assign w_w_hs    = (r_wstate == c_W_DATA) && s_axi_wvalid;
  assign w_w_last  = (r_wbeat == r_awlen);
  assign w_wr_addr = f_beat_addr(r_awaddr, r_awlen, r_awburst, r_wbeat);
  assign w_wr_idx  = w_wr_addr[c_IDX_W+2:3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_wstate <= c_W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  // Termination is by beat count; wlast only feeds the error response.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      c_W_IDLE: if (s_axi_awvalid)        w_wstate_nxt = c_W_DATA;
      c_W_DATA: if (w_w_hs && w_w_last)   w_wstate_nxt = c_W_RESP;
      c_W_RESP: if (s_axi_bready)         w_wstate_nxt = c_W_IDLE;
      default:                            w_wstate_nxt = c_W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = (r_wstate == c_W_IDLE);
    s_axi_wready  = (r_wstate == c_W_DATA);
    s_axi_bvalid  = (r_wstate == c_W_RESP);
    s_axi_bid     = r_awid;
    s_axi_bresp   = c_RESP_OKAY;
    if (r_wstate == c_W_RESP) begin
      if (r_dec_err)        s_axi_bresp = c_RESP_DECERR;
      else if (r_wlast_bad) s_axi_bresp = c_RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_awid      <= '0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_awburst   <= '0;
      r_wbeat     <= '0;
      r_wlast_bad <= 1'b0;
      r_dec_err   <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awid      <= s_axi_awid;
        r_awaddr    <= s_axi_awaddr;
        r_awlen     <= s_axi_awlen;
        r_awburst   <= s_axi_awburst;
        r_wbeat     <= '0;
        r_wlast_bad <= 1'b0;
        r_dec_err   <= 1'b0;
      end
      if (w_w_hs) begin
        r_wbeat <= r_wbeat + 8'd1;
        if (s_axi_wlast != w_w_last) r_wlast_bad <= 1'b1;
        if (w_wr_err)                r_dec_err   <= 1'b1;
      end
    end
  end

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_w_hs && !w_wr_err) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b])
          r_mem[w_wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  logic w_unused;
`ifdef AXI_MEM_ERR_RESP_EN
  assign w_rd_err = |w_rd_addr[ADDR_WIDTH-1:c_IDX_W+3];
  assign w_wr_err = |w_wr_addr[ADDR_WIDTH-1:c_IDX_W+3];
  assign w_unused = ^{s_axi_arsize, w_rd_addr[2:0], w_wr_addr[2:0]};
`else
  assign w_rd_err = 1'b0;
  assign w_wr_err = 1'b0;
  assign w_unused = ^{s_axi_arsize, w_rd_addr[ADDR_WIDTH-1:c_IDX_W+3], w_rd_addr[2:0],
                      w_wr_addr[ADDR_WIDTH-1:c_IDX_W+3], w_wr_addr[2:0]};
`endif

endmodule
`default_nettype wire
